// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

  localparam int unsigned CLK_HZ                   = 50_000_000;
  localparam int unsigned TXQ_DEPTH_DEFAULT        = 16;
  localparam int unsigned TXQ_BUSY_TIMEOUT_DEFAULT = 4;
  localparam int unsigned BYTE_W                   = 8;
  localparam int unsigned DROP_CNT_W               = 16;

  // Drain FSM states of the transmit queue.
  typedef enum logic [1:0] {
    TXQ_IDLE      = 2'd0,
    TXQ_LAUNCH    = 2'd1,
    TXQ_WAIT_BUSY = 2'd2,
    TXQ_WAIT_DONE = 2'd3
  } uart_txq_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte buffer with registered occupancy, full and empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = TXQ_DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [BYTE_W-1:0]       wr_data_i,
  input  logic                    pop_i,
  output logic [BYTE_W-1:0]       head_c,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Pointer and occupancy next-state; flags derived from the next count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a serial transmitter: drain FSM, sticky error flags and
// an optional dropped-write counter enabled by UART_TX_QUEUE_DROP_COUNT_EN.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = TXQ_DEPTH_DEFAULT,
  parameter int unsigned BUSY_TIMEOUT = TXQ_BUSY_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             tx_data,
  output logic                   start_tx,
  input  logic                   tx_ready,
  output logic                   overflow,
  output logic                   tx_err,
  input  logic                   clr_err
`ifdef UART_TX_QUEUE_DROP_COUNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  uart_txq_state_t   state_q, state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              start_tx_q, start_tx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              overflow_q, overflow_d;
  logic              tx_err_q, tx_err_d;
  logic              pop_c;
  logic              timeout_c;
  logic              drop_c;
  logic [BYTE_W-1:0] head_c;
  logic              fifo_full, fifo_empty;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push_i    (wr_en),
    .wr_data_i (wr_data),
    .pop_i     (pop_c),
    .head_c    (head_c),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

  // A write while full is dropped even if the drain pops in the same cycle.
  assign drop_c = wr_en & fifo_full;

  // Drain FSM next-state: pop on launch, watch the transmitter go busy then idle.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    timer_d   = timer_q;
    pop_c     = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      TXQ_IDLE: begin
        if (!fifo_empty && tx_ready) begin
          state_d   = TXQ_LAUNCH;
          tx_data_d = head_c;
          pop_c     = 1'b1;
        end
      end
      TXQ_LAUNCH: begin
        state_d = TXQ_WAIT_BUSY;
        timer_d = '0;
      end
      TXQ_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = TXQ_WAIT_DONE;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = TXQ_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      TXQ_WAIT_DONE: begin
        if (tx_ready) begin
          state_d = TXQ_IDLE;
        end
      end
      default: state_d = TXQ_IDLE;
    endcase
    start_tx_d = (state_d == TXQ_LAUNCH);
  end

  // Sticky flags; a new event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    overflow_d = drop_c | (overflow_q & ~clr_err);
    tx_err_d   = timeout_c | (tx_err_q & ~clr_err);
  end

  // FSM, launch data and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= TXQ_IDLE;
      tx_data_q  <= '0;
      start_tx_q <= 1'b0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      start_tx_q <= start_tx_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
    end
  end

`ifdef UART_TX_QUEUE_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-write counter; clear then count a concurrent drop.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_err) begin
      drop_cnt_d = '0;
    end
    if (drop_c && (drop_cnt_d != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_d + DROP_CNT_W'(1);
    end
  end

  // Dropped-write counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign tx_data  = tx_data_q;
  assign start_tx = start_tx_q;
  assign overflow = overflow_q;
  assign tx_err   = tx_err_q;

endmodule
